// File: rtl/infra_pkg.sv
// rtl/infra_pkg.sv - shared state encoding and default timing for the IR beam sensor
package infra_pkg;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_BURST = 2'd1,
      S_GAP   = 2'd2
   } infra_state_e;

   // Defaults assume a 50 MHz clock: 1 ms frames, ~38 kHz carrier
   localparam int FRAME_LEN_DEF       = 50000;
   localparam int BURST_LEN_DEF       = 25000;
   localparam int SAMPLE_AT_DEF       = 20000;
   localparam int CARRIER_HALF_DEF    = 658;
   localparam int DEBOUNCE_FRAMES_DEF = 3;

   localparam int FAULT_CNT_W = 8;

endpackage

// File: rtl/infra_debounce.sv
// rtl/infra_debounce.sv - per-frame verdict debouncer owning infra_out and fault
// INFRA_FAULT_CNT_EN adds a saturating fault-frame counter output.
module infra_debounce
   import infra_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic off_i,
   input  logic strobe_i,
   input  logic clear_i,
   input  logic fault_i,
   output logic infra_out_o,
   output logic fault_o
`ifdef INFRA_FAULT_CNT_EN
   ,
   output logic [FAULT_CNT_W-1:0] fault_cnt_o
`endif
);

   localparam int DB_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_FRAMES - 1);

   logic [DB_W-1:0] cnt_q, cnt_d;
   logic            out_q, out_d;
   logic            fault_q, fault_d;

   always_comb begin
      cnt_d   = cnt_q;
      out_d   = out_q;
      fault_d = fault_q;
      if (off_i) begin
         cnt_d   = '0;
         fault_d = 1'b0;
      end else if (strobe_i) begin
         // A fault frame says nothing about the beam, so the count is frozen
         if (fault_i) begin
            fault_d = 1'b1;
         end else begin
            fault_d = 1'b0;
            if (clear_i == out_q) begin
               cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
               out_d = clear_i;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         out_q   <= 1'b1;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         fault_q <= fault_d;
      end
   end

   assign infra_out_o = out_q;
   assign fault_o     = fault_q;

`ifdef INFRA_FAULT_CNT_EN
   logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;

   always_comb begin
      fcnt_d = fcnt_q;
      if (off_i) begin
         fcnt_d = '0;
      end else if (strobe_i && fault_i && (fcnt_q != '1)) begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
      end
   end

   assign fault_cnt_o = fcnt_q;
`endif

endmodule

// File: rtl/infra_beam_sense.sv
// rtl/infra_beam_sense.sv - IR emitter burst framing and lit/dark receiver sampling
// INFRA_FAULT_CNT_EN adds the fault_cnt output.
module infra_beam_sense
   import infra_pkg::*;
#(
   parameter int FRAME_LEN       = FRAME_LEN_DEF,
   parameter int BURST_LEN       = BURST_LEN_DEF,
   parameter int SAMPLE_AT       = SAMPLE_AT_DEF,
   parameter int CARRIER_HALF    = CARRIER_HALF_DEF,
   parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic rx_n,
   output logic tx_en,
   output logic infra_out,
   output logic fault,
   output logic frame_tick
`ifdef INFRA_FAULT_CNT_EN
   ,
   output logic [FAULT_CNT_W-1:0] fault_cnt
`endif
);

   localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int CC_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

   localparam logic [FC_W-1:0] FC_LAST       = FC_W'(FRAME_LEN - 1);
   localparam logic [FC_W-1:0] FC_BURST_LAST = FC_W'(BURST_LEN - 1);
   localparam logic [FC_W-1:0] FC_SAMPLE     = FC_W'(SAMPLE_AT);
   localparam logic [CC_W-1:0] CC_LAST       = CC_W'(CARRIER_HALF - 1);

   logic            rx_meta_q, rx_s_q;
   infra_state_e    state_q, state_d;
   logic [FC_W-1:0] fc_q, fc_d;
   logic [CC_W-1:0] cc_q, cc_d;
   logic            phase_q, phase_d;
   logic            tx_en_q, tx_en_d;
   logic            lit_ok_q, lit_ok_d;
   logic            db_off;

   // Receiver output is asynchronous to clk
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_n;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      fc_d    = fc_q;
      unique case (state_q)
         S_OFF: begin
            fc_d = '0;
            if (enable) state_d = S_BURST;
         end
         S_BURST: begin
            fc_d = fc_q + 1'b1;
            if (fc_q == FC_BURST_LAST) state_d = S_GAP;
         end
         S_GAP: begin
            if (fc_q == FC_LAST) begin
               fc_d    = '0;
               state_d = S_BURST;
            end else begin
               fc_d = fc_q + 1'b1;
            end
         end
         default: begin
            fc_d    = '0;
            state_d = S_OFF;
         end
      endcase
      if (!enable) begin
         state_d = S_OFF;
         fc_d    = '0;
      end
   end

   // Carrier is re-seeded on entry to fc=0 so each burst opens with phase high
   always_comb begin
      cc_d    = cc_q;
      phase_d = phase_q;
      if (state_d == S_OFF) begin
         cc_d    = '0;
         phase_d = 1'b0;
      end else if (fc_d == '0) begin
         cc_d    = '0;
         phase_d = 1'b1;
      end else if (cc_q == CC_LAST) begin
         cc_d    = '0;
         phase_d = ~phase_q;
      end else begin
         cc_d = cc_q + 1'b1;
      end
   end

   // Gating with enable keeps the emitter dark within one clock of disable
   assign tx_en_d  = enable & (state_q == S_BURST) & phase_q;
   assign lit_ok_d = ((state_q != S_OFF) && (fc_q == FC_SAMPLE)) ? ~rx_s_q : lit_ok_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_OFF;
         fc_q     <= '0;
         cc_q     <= '0;
         phase_q  <= 1'b0;
         tx_en_q  <= 1'b0;
         lit_ok_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         fc_q     <= fc_d;
         cc_q     <= cc_d;
         phase_q  <= phase_d;
         tx_en_q  <= tx_en_d;
         lit_ok_q <= lit_ok_d;
      end
   end

   assign tx_en      = tx_en_q;
   assign frame_tick = (state_q == S_GAP) && (fc_q == FC_LAST);
   assign db_off     = ~enable | (state_q == S_OFF);

   infra_debounce #(
      .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
   ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .off_i      (db_off),
      .strobe_i   (frame_tick),
      .clear_i    (lit_ok_q),
      .fault_i    (~rx_s_q),
      .infra_out_o(infra_out),
      .fault_o    (fault)
`ifdef INFRA_FAULT_CNT_EN
      ,
      .fault_cnt_o(fault_cnt)
`endif
   );

endmodule

// File: tb/tb_infra_beam_sense.sv
// tb/tb_infra_beam_sense.sv - scoreboard bench for infra_beam_sense (INFRA_FAULT_CNT_EN optional)
module tb_infra_beam_sense;

   localparam int FL = 100;
   localparam int BL = 50;
   localparam int SA = 40;
   localparam int CH = 4;
   localparam int DB = 3;

   localparam int M_NORMAL  = 0;
   localparam int M_BLOCKED = 1;
   localparam int M_AMBIENT = 2;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic rx_n = 1'b1;
   logic tx_en;
   logic infra_out;
   logic fault;
   logic frame_tick;
`ifdef INFRA_FAULT_CNT_EN
   logic [7:0] fault_cnt;
`endif

   always #5 clk = ~clk;

   infra_beam_sense #(
      .FRAME_LEN(FL),
      .BURST_LEN(BL),
      .SAMPLE_AT(SA),
      .CARRIER_HALF(CH),
      .DEBOUNCE_FRAMES(DB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .rx_n      (rx_n),
      .tx_en     (tx_en),
      .infra_out (infra_out),
      .fault     (fault),
      .frame_tick(frame_tick)
`ifdef INFRA_FAULT_CNT_EN
      ,
      .fault_cnt (fault_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   typedef struct {
      logic out;
      logic flt;
      int   fcnt;
   } exp_t;

   exp_t sb_q[$];

   int mode = M_NORMAL;
   int m_out = 1;
   int m_cnt = 0;
   int m_fault = 0;
   int m_fcnt = 0;

   // Frame-position model, rx stimulus and per-frame emitter/tick checks
   int pos = -1;
   bit started = 1'b0;
   int tx_err = 0;
   int tick_err = 0;

   always @(negedge clk) begin
      logic exp_tx;
      if (reset !== 1'b0 || enable !== 1'b1) begin
         pos = -1;
         started = 1'b0;
      end else if (!started) begin
         started = 1'b1;
      end else begin
         pos = (pos + 1) % FL;
      end

      case (mode)
         M_BLOCKED: rx_n = 1'b1;
         M_AMBIENT: rx_n = 1'b0;
         default:   rx_n = (pos >= 0 && pos < BL) ? 1'b0 : 1'b1;
      endcase

      if (pos >= 0) begin
         exp_tx = (pos >= 1 && pos <= BL && (((pos - 1) / CH) % 2 == 0));
         if (tx_en !== exp_tx) tx_err++;
         if (frame_tick !== (pos == FL - 1)) tick_err++;
         if (pos == FL - 1) begin
            check("tx_frame", tx_err, 0);
            check("tick_frame", tick_err, 0);
            tx_err = 0;
            tick_err = 0;
         end
      end else begin
         tx_err = 0;
         tick_err = 0;
      end
   end

   // Verdict lands on the clock that closes the tick cycle
   always @(negedge clk) begin
      exp_t e;
      if (frame_tick === 1'b1 && reset === 1'b0) begin
         @(negedge clk);
         if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("infra_out", infra_out, e.out);
            check("fault", fault, e.flt);
`ifdef INFRA_FAULT_CNT_EN
            check("fault_cnt", fault_cnt, e.fcnt);
`endif
         end
      end
   end

   task automatic run_frame(input int m);
      int n;
      mode = m;
      if (m == M_AMBIENT) begin
         m_fault = 1;
         if (m_fcnt < 255) m_fcnt++;
      end else begin
         m_fault = 0;
         if (((m == M_NORMAL) ? 1 : 0) == m_out) begin
            m_cnt = 0;
         end else begin
            m_cnt++;
            if (m_cnt == DB) begin
               m_out = (m == M_NORMAL) ? 1 : 0;
               m_cnt = 0;
            end
         end
      end
      sb_q.push_back('{m_out[0], m_fault[0], m_fcnt});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 3 * FL);
      if (frame_tick !== 1'b1) check("frame_timeout", 0, 1);
   endtask

   task automatic wait_pos(input int p);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pos != p && n < 3 * FL);
      if (pos != p) check("pos_timeout", 0, 1);
   endtask

   initial begin
      int ticks;
      reset  = 1'b1;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_en", tx_en, 0);
      check("rst_infra_out", infra_out, 1);
      check("rst_fault", fault, 0);
      check("rst_frame_tick", frame_tick, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      enable = 1'b1;

      run_frame(M_NORMAL);
      run_frame(M_NORMAL);

      // Two blocked frames then clear, twice: count must restart each time
      run_frame(M_BLOCKED);
      run_frame(M_BLOCKED);
      run_frame(M_NORMAL);
      run_frame(M_BLOCKED);
      run_frame(M_BLOCKED);
      run_frame(M_NORMAL);

      run_frame(M_BLOCKED);
      run_frame(M_BLOCKED);
      run_frame(M_BLOCKED);

      run_frame(M_AMBIENT);
      run_frame(M_AMBIENT);
      run_frame(M_AMBIENT);
      run_frame(M_NORMAL);
      run_frame(M_NORMAL);

      wait_pos(20);
      @(posedge clk);
      #1;
      enable  = 1'b0;
      m_cnt   = 0;
      m_fault = 0;
      m_fcnt  = 0;
      @(negedge clk);
      @(negedge clk);
      check("tx_off", tx_en, 0);
      ticks = 0;
      repeat (250) begin
         @(negedge clk);
         if (frame_tick !== 1'b0) ticks++;
      end
      check("tick_off", ticks, 0);
      check("fault_off", fault, 0);
      check("out_hold_off", infra_out, 0);
`ifdef INFRA_FAULT_CNT_EN
      check("fault_cnt_off", fault_cnt, 0);
`endif

      @(posedge clk);
      #1;
      enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("restart_fc0", tx_en, 0);
      @(negedge clk);
      check("restart_phase_hi", tx_en, 1);
      run_frame(M_NORMAL);
      run_frame(M_NORMAL);

      wait_pos(60);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_infra_out", infra_out, 1);
      check("midrst_fault", fault, 0);
      check("midrst_tx_en", tx_en, 0);
      check("midrst_frame_tick", frame_tick, 0);
      reset   = 1'b0;
      m_out   = 1;
      m_cnt   = 0;
      m_fault = 0;
      m_fcnt  = 0;
      run_frame(M_NORMAL);
      run_frame(M_NORMAL);

      @(negedge clk);
      @(negedge clk);
      check("sb_drain", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/infra_beam_sense.md
Name: infra_beam_sense

Overview:
- Upstream stage of the infrared ball-sensor PIO. Drives the IR emitter with a gated carrier burst once per frame and samples the demodulating receiver in two windows: lit (emitter on) and dark (emitter off).
- Debounces the per-frame verdict into a clean level, infra_out, which feeds the PIO input port. A falling edge on infra_out means the ball has broken the beam; the PIO turns that edge into an IRQ.

Parameters:
- FRAME_LEN, 50000: clocks per frame (1 ms at 50 MHz).
- BURST_LEN, 25000: clocks at frame start during which the carrier is gated on.
- SAMPLE_AT, 20000: frame position of the lit sample.
- CARRIER_HALF, 658: carrier half-period in clocks (about 38 kHz at 50 MHz).
- DEBOUNCE_FRAMES, 3: consecutive valid disagreeing frames needed to change infra_out.
- Legal ranges: 0 < SAMPLE_AT < BURST_LEN < FRAME_LEN-1; CARRIER_HALF >= 1; DEBOUNCE_FRAMES >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  sensing enable from the CPU control register
- rx_n  in  1  receiver output, asynchronous; 0 = carrier detected
- tx_en  out  1  emitter drive, registered
- infra_out  out  1  1 = beam clear, 0 = beam blocked
- fault  out  1  last completed frame saw reception in the dark window (ambient light or saturation)
- frame_tick  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset values: tx_en=0, infra_out=1, fault=0, frame_tick=0. Frame counter fc=0, carrier counter and phase=0, debounce count=0, state=S_OFF.
- Reset takes priority over every other input and may be asserted at any point mid-frame.
- rx_n passes through a 2-flop synchronizer (rx_s) before any use. This synchronizer is always present.
- States: S_OFF, S_BURST, S_GAP.
  - S_OFF: entered while enable=0. fc is held at 0, carrier is cleared, debounce count is cleared, fault is cleared, and infra_out holds its value. When enable=1, go to S_BURST with fc=0.
  - S_BURST: covers fc 0..BURST_LEN-1. At fc=BURST_LEN-1, go to S_GAP.
  - S_GAP: covers fc BURST_LEN..FRAME_LEN-1. At fc=FRAME_LEN-1, fc wraps to 0 and the state returns to S_BURST.
  - enable=0 in any state forces S_OFF on the next clock.
- Carrier: the phase toggles every CARRIER_HALF clocks. The carrier counter and phase reset at fc=0, so every burst starts with phase high.
- Emitter: tx_en is registered from (state==S_BURST & phase), giving 1 cycle of latency. tx_en is 0 throughout S_GAP and S_OFF.
- Lit sample: lit_ok = ~rx_s, captured at fc==SAMPLE_AT.
- Dark sample and verdict: at fc==FRAME_LEN-1, dark_ok = rx_s is sampled and frame_tick pulses. The frame verdict is then:
  - dark_ok=0: fault frame. fault<=1; debounce count and infra_out are untouched.
  - dark_ok=1: fault<=0 and clear=lit_ok.
    - If clear==infra_out, the count clears to 0.
    - Otherwise the count increments. When it reaches DEBOUNCE_FRAMES, infra_out<=clear and the count clears in the same cycle.
- Fault frames neither advance nor reset the debounce count.
- Counter widths are $clog2 of the maximum value. All counters are unsigned and wrap only at the stated bounds.

Optional Feature:
- Macro: INFRA_FAULT_CNT_EN.
- When defined: adds output port fault_cnt, 8 bits, a saturating count of fault frames.
  - Reset value 0.
  - Increments on each fault verdict and saturates at 255.
  - Clears when enable=0.
- When undefined: no fault_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Package infra_pkg holds:
  - the state enum (S_OFF, S_BURST, S_GAP);
  - default constants for FRAME_LEN, BURST_LEN, SAMPLE_AT, CARRIER_HALF and DEBOUNCE_FRAMES;
  - the FAULT_CNT_W=8 constant.
- One sub-module, infra_debounce. It takes the frame verdict strobe, clear and fault inputs, and owns the debounce count, infra_out and fault. The frame/carrier FSM remains in the top level.

Test Plan (sim params FRAME_LEN=100, BURST_LEN=50, SAMPLE_AT=40, CARRIER_HALF=4, DEBOUNCE_FRAMES=3):
- Reset, then enable=1, with the rx model driving rx_n=0 while the burst is active and 1 otherwise -> tx_en toggles every 4 clocks within frame cycles 1..50 and is 0 elsewhere; frame_tick every 100 clocks; infra_out stays 1; fault=0.
- Beam blocked (rx_n=1 constantly) starting at frame 2 -> infra_out stays 1 after the 2nd blocked frame and falls to 0 one clock after the 3rd blocked frame_tick.
- Blocked for 2 frames, then clear -> infra_out never leaves 1; debounce count returns to 0.
- rx_n=0 constantly -> fault=1 after the first frame_tick; infra_out and debounce count frozen; fault_cnt (when INFRA_FAULT_CNT_EN is defined) counts 1,2,3 per frame. Restore the normal rx model -> fault=0 at the next frame_tick.
- Drop enable at fc=20 -> tx_en=0 within 1 clock and frame_tick stops. Re-enable -> the burst restarts at fc=0 with phase high.
- Assert reset mid-frame while infra_out=0 -> next clock: infra_out=1, fault=0, tx_en=0, fc=0.
